// File: rtl/lockstep_divergence_monitor.sv
// Lockstep divergence monitor: compares a golden core's PC/Result against
// NUM_CH faulty cores every enabled cycle. It keeps sticky per-channel
// divergence flags and saturating mismatch statistics. Timestamped divergence
// records pass through one pending slot per channel into a show-ahead FIFO
// that a consumer drains with a valid/ready handshake.
//
// Ports:
//   clk, rst (async, active low)
//   en, clear, log_all, ch_mask       - compare control
//   pc_golden, result_golden          - golden core reference
//   pc_faulty, result_faulty          - packed faulty channels, ch i at [i*WIDTH +: WIDTH]
//   cycle_count, diverged, any_diverged, first_div_cycle, mismatch_count - statistics
//   rec_valid, rec_ready, rec_ch, rec_cycle, rec_kind - record stream (show-ahead)
//   overflow                          - sticky event-drop indicator
module lockstep_divergence_monitor #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clear,
  input  logic                      log_all,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic [WIDTH-1:0]          pc_golden,
  input  logic [WIDTH-1:0]          result_golden,
  input  logic [NUM_CH*WIDTH-1:0]   pc_faulty,
  input  logic [NUM_CH*WIDTH-1:0]   result_faulty,
  input  logic                      rec_ready,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [NUM_CH-1:0]         diverged,
  output logic                      any_diverged,
  output logic [NUM_CH*CNT_W-1:0]   first_div_cycle,
  output logic [NUM_CH*CNT_W-1:0]   mismatch_count,
  output logic                      rec_valid,
  output logic [CH_W-1:0]           rec_ch,
  output logic [CNT_W-1:0]          rec_cycle,
  output logic [1:0]                rec_kind,
  output logic                      overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] pend_valid;
  logic [CNT_W-1:0]  pend_cycle [NUM_CH];
  logic [1:0]        pend_kind  [NUM_CH];

  logic [CH_W-1:0]   mem_ch    [DEPTH];
  logic [CNT_W-1:0]  mem_cycle [DEPTH];
  logic [1:0]        mem_kind  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ, occ_next_c;

  logic              sample_c, pop_c, push_c, full_c;
  logic [1:0]        kind_c [NUM_CH];
  logic [NUM_CH-1:0] event_c, queue_c, drain_c, load_c, drop_c;
  logic [CH_W-1:0]   sel_c;

  // Per-channel compare and record qualification
  always_comb begin
    sample_c = en && !clear;
    kind_c   = '{default: 2'b00};
    event_c  = '0;
    queue_c  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      kind_c[i]  = {result_faulty[i*WIDTH +: WIDTH] != result_golden,
                    pc_faulty[i*WIDTH +: WIDTH] != pc_golden};
      event_c[i] = sample_c && ch_mask[i] && (kind_c[i] != 2'b00);
      queue_c[i] = event_c[i] && (log_all || !diverged[i]);
    end
  end

  // Fixed-priority arbiter from pending slots into the FIFO
  always_comb begin
    pop_c  = rec_valid && rec_ready;
    full_c = (occ == OCC_W'(DEPTH));
    sel_c  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_valid[i]) sel_c = CH_W'(i);
    end
    push_c  = (|pend_valid) && (!full_c || pop_c);
    drain_c = '0;
    load_c  = '0;
    drop_c  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      drain_c[i] = push_c && (sel_c == CH_W'(i));
      // A slot drained this edge can take the new event without loss
      load_c[i]  = queue_c[i] && (!pend_valid[i] || drain_c[i]);
      drop_c[i]  = queue_c[i] && pend_valid[i] && !drain_c[i];
    end
    occ_next_c = occ;
    case ({push_c, pop_c})
      2'b10:   occ_next_c = occ + OCC_W'(1);
      2'b01:   occ_next_c = occ - OCC_W'(1);
      default: occ_next_c = occ;
    endcase
  end

  // Statistics: cycle counter, sticky flags, per-channel counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count     <= '0;
      diverged        <= '0;
      any_diverged    <= 1'b0;
      first_div_cycle <= '0;
      mismatch_count  <= '0;
      overflow        <= 1'b0;
    end else if (clear) begin
      cycle_count     <= '0;
      diverged        <= '0;
      any_diverged    <= 1'b0;
      first_div_cycle <= '0;
      mismatch_count  <= '0;
      overflow        <= 1'b0;
    end else begin
      if (sample_c && cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_W'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (event_c[i]) begin
          if (mismatch_count[i*CNT_W +: CNT_W] != CNT_MAX)
            mismatch_count[i*CNT_W +: CNT_W] <= mismatch_count[i*CNT_W +: CNT_W] + CNT_W'(1);
          if (!diverged[i]) begin
            diverged[i]                       <= 1'b1;
            first_div_cycle[i*CNT_W +: CNT_W] <= cycle_count;
          end
        end
      end
      if (|event_c) any_diverged <= 1'b1;
      if (|drop_c)  overflow     <= 1'b1;
    end
  end

  // Pending slots: one outstanding record per channel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_cycle[i] <= '0;
        pend_kind[i]  <= '0;
      end
    end else if (clear) begin
      pend_valid <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_cycle[i] <= '0;
        pend_kind[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load_c[i]) begin
          pend_valid[i] <= 1'b1;
          pend_cycle[i] <= cycle_count;
          pend_kind[i]  <= kind_c[i];
        end else if (drain_c[i]) begin
          pend_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Record FIFO storage and pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      rec_valid <= 1'b0;
      for (int d = 0; d < DEPTH; d++) begin
        mem_ch[d]    <= '0;
        mem_cycle[d] <= '0;
        mem_kind[d]  <= '0;
      end
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      rec_valid <= 1'b0;
      for (int d = 0; d < DEPTH; d++) begin
        mem_ch[d]    <= '0;
        mem_cycle[d] <= '0;
        mem_kind[d]  <= '0;
      end
    end else begin
      if (push_c) begin
        mem_ch[wr_ptr]    <= sel_c;
        mem_cycle[wr_ptr] <= pend_cycle[sel_c];
        mem_kind[wr_ptr]  <= pend_kind[sel_c];
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      occ       <= occ_next_c;
      rec_valid <= (occ_next_c != '0);
    end
  end

  // Show-ahead head of the FIFO
  always_comb begin
    rec_ch    = mem_ch[rd_ptr];
    rec_cycle = mem_cycle[rd_ptr];
    rec_kind  = mem_kind[rd_ptr];
  end

endmodule

// File: tb/tb_lockstep_divergence_monitor.sv
// Bench for lockstep_divergence_monitor: a vector table of single-cycle
// divergence patterns, plus sequences for latency, drain order, overflow,
// masking/clear and asynchronous reset. Records are checked via a scoreboard.
module tb_lockstep_divergence_monitor;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DEPTH  = 8;

  logic                     clk;
  logic                     rst;
  logic                     en;
  logic                     clear;
  logic                     log_all;
  logic [NUM_CH-1:0]        ch_mask;
  logic [WIDTH-1:0]         pc_golden;
  logic [WIDTH-1:0]         result_golden;
  logic [NUM_CH*WIDTH-1:0]  pc_faulty;
  logic [NUM_CH*WIDTH-1:0]  result_faulty;
  logic                     rec_ready;
  logic [CNT_W-1:0]         cycle_count;
  logic [NUM_CH-1:0]        diverged;
  logic                     any_diverged;
  logic [NUM_CH*CNT_W-1:0]  first_div_cycle;
  logic [NUM_CH*CNT_W-1:0]  mismatch_count;
  logic                     rec_valid;
  logic [1:0]               rec_ch;
  logic [CNT_W-1:0]         rec_cycle;
  logic [1:0]               rec_kind;
  logic                     overflow;

  lockstep_divergence_monitor #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .log_all(log_all),
    .ch_mask(ch_mask), .pc_golden(pc_golden), .result_golden(result_golden),
    .pc_faulty(pc_faulty), .result_faulty(result_faulty), .rec_ready(rec_ready),
    .cycle_count(cycle_count), .diverged(diverged), .any_diverged(any_diverged),
    .first_div_cycle(first_div_cycle), .mismatch_count(mismatch_count),
    .rec_valid(rec_valid), .rec_ch(rec_ch), .rec_cycle(rec_cycle),
    .rec_kind(rec_kind), .overflow(overflow)
  );

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] cyc;
    logic [1:0]  kind;
  } rec_t;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] pc_err;
    logic [3:0] res_err;
    logic [3:0] exp_div;
  } vec_t;

  rec_t       sb[$];
  vec_t       vecs[7];
  logic [3:0] pc_err;
  logic [3:0] res_err;
  int         checks;
  int         errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mc(input int i);
    return mismatch_count[i*16 +: 16];
  endfunction

  function automatic logic [15:0] fdc(input int i);
    return first_div_cycle[i*16 +: 16];
  endfunction

  // Fresh golden data each cycle; faulty copies perturbed per error masks
  task automatic step();
    pc_golden     = $urandom;
    result_golden = $urandom;
    for (int i = 0; i < 4; i++) begin
      pc_faulty[i*32 +: 32]     = pc_golden ^ (pc_err[i] ? 32'h0000_0400 : 32'h0);
      result_faulty[i*32 +: 32] = result_golden ^ (res_err[i] ? 32'h8000_0001 : 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  // Clear with compare enabled and all channels mismatching: clear must win
  task automatic do_clear();
    clear   = 1'b1;
    en      = 1'b1;
    pc_err  = 4'hF;
    step();
    clear   = 1'b0;
    en      = 1'b0;
    pc_err  = 4'h0;
    res_err = 4'h0;
    sb.delete();
  endtask

  task automatic push_exp(input int ch, input int cyc, input logic [1:0] kind);
    rec_t e;
    e.ch   = 2'(ch);
    e.cyc  = 16'(cyc);
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    rec_t e;
    rec_ready = 1'b1;
    for (int n = 0; n < budget; n++) begin
      if (!rec_valid && sb.size() == 0) break;
      if (rec_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rec_extra: got ch=%0d cycle=%0d kind=%0d, expected no record",
                   rec_ch, rec_cycle, rec_kind);
        end else begin
          e = sb.pop_front();
          check("rec", {rec_ch, rec_cycle, rec_kind}, {e.ch, e.cyc, e.kind});
        end
      end
      step();
    end
    check("drain_left", 64'(sb.size()), 64'd0);
    step();
    step();
    check("drain_idle", rec_valid, 1'b0);
    rec_ready = 1'b0;
  endtask

  initial begin
    rec_t e;
    checks = 0;
    errors = 0;
    rst = 1'b0; en = 1'b0; clear = 1'b0; log_all = 1'b0; ch_mask = 4'hF;
    rec_ready = 1'b0; pc_err = 4'h0; res_err = 4'h0;
    pc_golden = '0; result_golden = '0; pc_faulty = '0; result_faulty = '0;

    vecs[0] = '{mask: 4'hF, pc_err: 4'h0, res_err: 4'h0, exp_div: 4'h0};
    vecs[1] = '{mask: 4'hF, pc_err: 4'h1, res_err: 4'h0, exp_div: 4'h1};
    vecs[2] = '{mask: 4'hF, pc_err: 4'h0, res_err: 4'h4, exp_div: 4'h4};
    vecs[3] = '{mask: 4'hF, pc_err: 4'hB, res_err: 4'h0, exp_div: 4'hB};
    vecs[4] = '{mask: 4'hE, pc_err: 4'h1, res_err: 4'h1, exp_div: 4'h0};
    vecs[5] = '{mask: 4'hF, pc_err: 4'hC, res_err: 4'h6, exp_div: 4'hE};
    vecs[6] = '{mask: 4'h5, pc_err: 4'hF, res_err: 4'hF, exp_div: 4'h5};

    // Reset state
    step();
    step();
    check("rst_cycle_count", cycle_count, 16'd0);
    check("rst_rec_valid", rec_valid, 1'b0);
    check("rst_diverged", diverged, 4'h0);
    check("rst_overflow", overflow, 1'b0);
    rst = 1'b1;
    step();

    // Identical streams for 20 enabled cycles
    do_clear();
    en = 1'b1;
    repeat (20) step();
    en = 1'b0;
    step();
    check("clean_cycle_count", cycle_count, 16'd20);
    check("clean_diverged", diverged, 4'h0);
    check("clean_rec_valid", rec_valid, 1'b0);
    check("clean_overflow", overflow, 1'b0);

    // Table: one sampled cycle at tag 0, then drain
    for (int v = 0; v < 7; v++) begin
      do_clear();
      ch_mask = vecs[v].mask;
      pc_err  = vecs[v].pc_err;
      res_err = vecs[v].res_err;
      en      = 1'b1;
      for (int i = 0; i < 4; i++)
        if (vecs[v].exp_div[i]) push_exp(i, 0, {vecs[v].res_err[i], vecs[v].pc_err[i]});
      step();
      en = 1'b0; pc_err = 4'h0; res_err = 4'h0; ch_mask = 4'hF;
      check($sformatf("vec%0d_diverged", v), diverged, vecs[v].exp_div);
      check($sformatf("vec%0d_any", v), any_diverged, |vecs[v].exp_div);
      for (int i = 0; i < 4; i++)
        check($sformatf("vec%0d_mc%0d", v, i), mc(i), {15'd0, vecs[v].exp_div[i]});
      check($sformatf("vec%0d_lat_edge0", v), rec_valid, 1'b0);
      drain(20);
    end

    // Channel 2 Result mismatch at tag 5, latency and hold under backpressure
    do_clear();
    en = 1'b1;
    repeat (5) step();
    res_err = 4'h4;
    push_exp(2, 5, 2'b10);
    step();
    res_err = 4'h0;
    check("b_diverged", diverged, 4'b0100);
    check("b_first_div2", fdc(2), 16'd5);
    check("b_mc2", mc(2), 16'd1);
    check("b_rec_valid_n", rec_valid, 1'b0);
    step();
    check("b_rec_valid_n1", rec_valid, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b_hold%0d", k), {rec_ch, rec_cycle, rec_kind}, {2'd2, 16'd5, 2'b10});
      step();
    end
    en = 1'b0;
    check("b_mc2_after", mc(2), 16'd1);
    drain(20);

    // Channels 0,1,3 PC mismatch at tag 3, records on consecutive cycles
    do_clear();
    en = 1'b1;
    rec_ready = 1'b1;
    repeat (3) step();
    pc_err = 4'b1011;
    push_exp(0, 3, 2'b01);
    push_exp(1, 3, 2'b01);
    push_exp(3, 3, 2'b01);
    step();
    pc_err = 4'h0;
    en = 1'b0;
    check("c_lat_edge0", rec_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("c_valid%0d", k), rec_valid, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check($sformatf("c_rec%0d", k), {rec_ch, rec_cycle, rec_kind}, {e.ch, e.cyc, e.kind});
      end
    end
    step();
    check("c_empty", rec_valid, 1'b0);
    rec_ready = 1'b0;

    // log_all, 12 consecutive mismatches with no consumer: FIFO full, one pending, drops
    do_clear();
    log_all = 1'b1;
    en = 1'b1;
    res_err = 4'h1;
    for (int t = 0; t < 12; t++) begin
      if (t <= DEPTH) push_exp(0, t, 2'b10);
      step();
    end
    en = 1'b0; res_err = 4'h0; log_all = 1'b0;
    step();
    check("d_overflow", overflow, 1'b1);
    check("d_mc0", mc(0), 16'd12);
    check("d_first_div0", fdc(0), 16'd0);
    check("d_head", {rec_valid, rec_cycle}, {1'b1, 16'd0});
    drain(40);

    // Masked channel 0 diverging, channel 1 logged, then clear
    do_clear();
    ch_mask = 4'b1110;
    log_all = 1'b1;
    pc_err  = 4'b0011;
    en = 1'b1;
    repeat (3) step();
    en = 1'b0; pc_err = 4'h0; log_all = 1'b0;
    step();
    check("e_diverged", diverged, 4'b0010);
    check("e_mc0", mc(0), 16'd0);
    check("e_mc1", mc(1), 16'd3);
    check("e_head_ch", {rec_valid, rec_ch}, {1'b1, 2'd1});
    do_clear();
    ch_mask = 4'hF;
    check("e_clr_cycle", cycle_count, 16'd0);
    check("e_clr_div", {any_diverged, diverged}, 5'd0);
    check("e_clr_rec", {rec_valid, overflow}, 2'd0);
    check("e_clr_mc", 64'(mismatch_count), 64'd0);
    check("e_clr_fdc", 64'(first_div_cycle), 64'd0);

    // Asynchronous reset while a record is visible
    do_clear();
    pc_err = 4'hF;
    en = 1'b1;
    step();
    pc_err = 4'h0;
    en = 1'b0;
    step();
    check("f_pre_valid", rec_valid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("f_rst_valid", rec_valid, 1'b0);
    check("f_rst_div", diverged, 4'h0);
    check("f_rst_cnt", {cycle_count, mc(0)}, 32'd0);
    #1;
    rst = 1'b1;
    sb.delete();
    step();
    step();
    check("f_post_valid", rec_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lockstep_divergence_monitor.md
# lockstep_divergence_monitor

Per-cycle lockstep comparator for the golden/faulty fault-injection harness. Samples the golden core's PC and Result alongside NUM_CH faulty cores, flags divergence per channel, keeps per-channel mismatch statistics, and queues timestamped divergence records in a show-ahead FIFO drained by a valid/ready handshake. It sits beside the comparison top, fed by its PC/Result outputs, and replaces waveform inspection for fault-campaign classification.

## Interface
- WIDTH, 32, width of PC and Result buses
- NUM_CH, 4, number of faulty channels (1..16)
- CNT_W, 16, width of cycle and count fields
- DEPTH, 8, record FIFO depth (power of two, >= 2)
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  compare enable; sampling and cycle counting only when 1
- clear  input  1  synchronous clear of all state to reset values; priority over en
- log_all  input  1  0: record first divergence per channel only; 1: record every mismatching cycle
- ch_mask  input  NUM_CH  1 = channel compared; 0 = ignored
- pc_golden  input  WIDTH  golden PC
- result_golden  input  WIDTH  golden Result
- pc_faulty  input  NUM_CH*WIDTH  faulty PCs, channel i at [i*WIDTH +: WIDTH]
- result_faulty  input  NUM_CH*WIDTH  faulty Results, same packing
- rec_ready  input  1  consumer accepts head record
- cycle_count  output  CNT_W  number of enabled cycles sampled
- diverged  output  NUM_CH  sticky per-channel divergence flag
- any_diverged  output  1  OR of diverged
- first_div_cycle  output  NUM_CH*CNT_W  cycle tag of first divergence per channel
- mismatch_count  output  NUM_CH*CNT_W  mismatching cycles per channel
- rec_valid  output  1  FIFO non-empty
- rec_ch  output  clog2(NUM_CH), min 1  channel of head record
- rec_cycle  output  CNT_W  cycle tag of head record
- rec_kind  output  2  bit0 PC mismatch, bit1 Result mismatch
- overflow  output  1  sticky: at least one event dropped

## Operation
- Reset (rst=0, async) and clear: all outputs and internal state 0; FIFO empty; pending flags 0.
- Sampling (edge with en=1, clear=0): tag T = current cycle_count. For each channel i with ch_mask[i]=1: kind = {result_faulty_i != result_golden, pc_faulty_i != pc_golden}. If kind != 0 it is an event.
- Event on channel i: mismatch_count[i] += 1 (saturating at all-ones); if diverged[i]=0, set diverged[i] and first_div_cycle[i]=T. cycle_count += 1, saturating.
- Record generation: an event is queued if log_all=1, or if it is the channel's first divergence. Queued event loads per-channel pending slot {T, kind}.
- Pending collision: if channel i's slot is still occupied and not being drained this edge, new event is dropped, overflow set; statistics still update.
- Arbiter: each cycle, lowest-index occupied pending slot is pushed into FIFO if FIFO not full (or full and popping this edge). One push per cycle. Slot drained and reloaded on same edge: new event wins, no drop.
- FIFO full: pending slots hold (backpressure); no drop at FIFO itself.
- Pop: rec_valid && rec_ready at edge removes head. Read pointer wraps modulo DEPTH.
- en=0: no sampling, counts frozen; arbiter and pops continue.
- Masked channel: no events, statistics frozen; pending slot still drains.

## Timing
- Sampling registered: event sampled at edge N shows in diverged/mismatch_count/first_div_cycle after edge N.
- Pending loaded at edge N; earliest push at edge N+1; rec_valid high after edge N+1 (latency 2 edges from sampled mismatch to visible record).
- k simultaneous first divergences drain one per cycle, lowest channel first.
- rec_* stable while rec_valid=1 and rec_ready=0.
- Push and pop on same edge with FIFO full: both occur, occupancy unchanged.
- Reset asserted mid-drain: FIFO, pending and counters cleared immediately; rec_valid falls asynchronously.

## Test plan
- Identical golden/faulty streams, en=1 for 20 cycles -> cycle_count=20, diverged=0, rec_valid=0, overflow=0.
- Channel 2 Result differs at tag 5 only, log_all=0 -> diverged=4'b0100, first_div_cycle[2]=5, mismatch_count[2]=1; one record {ch=2, cycle=5, kind=2'b10} visible two edges after sample.
- Channels 0,1,3 PC differ at tag 3, log_all=0, rec_ready=1 -> records ch0, ch1, ch3 on consecutive cycles, all cycle=3, kind=2'b01.
- log_all=1, channel 0 mismatches 12 consecutive cycles, rec_ready=0, DEPTH=8 -> 8 records queued, one held pending, overflow=1, mismatch_count[0]=12.
- ch_mask=4'b1110 with channel 0 diverging -> no channel-0 records or counts; then clear=1 one cycle -> all outputs 0.
- rst pulled low while rec_valid=1 -> rec_valid, counts, diverged 0 before next edge.
